// File: rtl/mult_div_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_div_pkg
// Brief    : Shared FSM encoding and sizing constants for mult_div_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mult_div_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic int step_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int c_STEP_CNT_W = step_cnt_width(c_DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_div_step.sv
//------------------------------------------------------------------------------
// Module   : div_step
// Brief    : One combinational restoring-division step (shift, trial subtract).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;

    assign w_shifted = {rem_in, bit_in};
    assign q_bit     = (w_shifted >= {1'b0, divisor});
    // When the subtract succeeds the true difference is below divisor, so W bits suffice.
    assign w_diff    = w_shifted[WIDTH-1:0] - divisor;
    assign rem_out   = q_bit ? w_diff : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// Module   : mult_div_unit
// Brief    : Iterative signed multiply (radix-2 Booth) / divide (restoring).
//            Optional macro DIV_ZERO_EXC_EN: early exit with div_zero on b=0.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int c_CNT_W = (WIDTH == c_DEFAULT_WIDTH) ? c_STEP_CNT_W : step_cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_rem;
    logic             r_q_m1;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_last;
    logic             w_dz_exit;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_quot;

    assign busy    = (r_state != ST_IDLE);
    assign w_last  = (r_cnt == c_LAST);
    assign w_abs_a = a[WIDTH-1] ? -a : a;
    assign w_abs_b = b[WIDTH-1] ? -b : b;
    // One guard bit keeps acc +/- M from overflowing when M is the most negative value.
    assign w_m_ext = {r_m[WIDTH-1], r_m};
    assign w_quot  = {r_q[WIDTH-2:0], w_q_bit};

    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_q_m1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
    end

    div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .rem_in  (r_rem),
        .bit_in  (r_q[WIDTH-1]),
        .divisor (r_m),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

`ifdef DIV_ZERO_EXC_EN
    logic r_b_zero;
    logic r_div_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_zero   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= w_dz_exit;
            if (r_state == ST_IDLE && !start_mult && start_div) begin
                r_b_zero <= (b == '0);
            end
        end
    end

    assign w_dz_exit = (r_state == ST_DIV) && r_b_zero;
    assign div_zero  = r_div_zero;
`else
    assign w_dz_exit = 1'b0;
    assign div_zero  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_mult) begin
                    w_next_state = ST_MULT;
                end else if (start_div) begin
                    w_next_state = ST_DIV;
                end
            end
            ST_MULT: begin
                if (w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (w_last || w_dz_exit) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_rem   <= '0;
            r_q_m1  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_mult) begin
                        r_acc  <= '0;
                        r_q    <= a;
                        r_m    <= b;
                        r_q_m1 <= 1'b0;
                        r_cnt  <= '0;
                    end else if (start_div) begin
                        r_rem   <= '0;
                        r_q     <= w_abs_a;
                        r_m     <= w_abs_b;
                        r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r <= a[WIDTH-1];
                        r_cnt   <= '0;
                    end
                end
                ST_MULT: begin
                    r_acc  <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                    r_q    <= {w_booth_sum[0], r_q[WIDTH-1:1]};
                    r_q_m1 <= r_q[0];
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        hi   <= w_booth_sum[WIDTH:1];
                        lo   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
                        done <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (w_dz_exit) begin
                        done <= 1'b1;
                    end else begin
                        r_rem <= w_rem_next;
                        r_q   <= w_quot;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (w_last) begin
                            lo   <= r_neg_q ? -w_quot : w_quot;
                            hi   <= r_neg_r ? -w_rem_next : w_rem_next;
                            done <= 1'b1;
                        end
                    end
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire
